// File: rtl/sonar_pkg.sv
// Shared definitions for the parametrised ultrasonic ranger front end.
// State codes, cycle conversion helper and BCD constants.
package sonar_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_TRIG = 4'd1,
    S_WAIT = 4'd2,
    S_MEAS = 4'd3,
    S_DONE = 4'd4,
    S_TOUT = 4'd5
  } state_e;

  function automatic int unsigned US_TO_CYCLES(
    input int unsigned us,
    input int unsigned hz
  );
    longint unsigned p;
    p = 64'(us) * 64'(hz) / 64'd1000000;
    return 32'(p);
  endfunction

  function automatic logic [3*DIG_W-1:0] TO_BCD(
    input int unsigned v
  );
    return {DIG_W'(v / 100 % 10),
            DIG_W'(v / 10 % 10),
            DIG_W'(v % 10)};
  endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD up counter with synchronous clear,
// enable and saturation at a BCD limit.
module contador_bcd_3dig
  import sonar_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [3*DIG_W-1:0] limit,
  output logic [3*DIG_W-1:0] count
);

  logic [3*DIG_W-1:0] count_q, count_d;
  logic [DIG_W-1:0]   u, d, c;

  assign u = count_q[DIG_W-1:0];
  assign d = count_q[2*DIG_W-1:DIG_W];
  assign c = count_q[3*DIG_W-1:2*DIG_W];

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && count_q != limit) begin
      if (u != DIG_W'(9)) begin
        count_d[DIG_W-1:0] = u + 1'b1;
      end else begin
        count_d[DIG_W-1:0] = '0;
        if (d != DIG_W'(9)) begin
          count_d[2*DIG_W-1:DIG_W] = d + 1'b1;
        end else begin
          count_d[2*DIG_W-1:DIG_W] = '0;
          count_d[3*DIG_W-1:2*DIG_W] =
            (c == DIG_W'(9)) ? '0 : c + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/interface_sonar_param.sv
// Ultrasonic ranger: trigger, echo timing, rounded BCD cm result.
// Optional echo timeout enabled by defining SONAR_TIMEOUT_EN.
module interface_sonar_param
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned TRIG_US       = 10,
  parameter int unsigned CYCLES_PER_CM = 2941,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_US    = 30000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned TRIG_CYC = US_TO_CYCLES(TRIG_US, CLK_HZ);
  localparam int unsigned TOUT_CYC = US_TO_CYCLES(TIMEOUT_US, CLK_HZ);
  localparam int unsigned CNT_MAX  =
    (TOUT_CYC > TRIG_CYC) ? TOUT_CYC : TRIG_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(CYCLES_PER_CM);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    sync_q, sync_d;
  logic          trigger_q, trigger_d;
  logic          pronto_q, pronto_d;
  logic [11:0]   medida_q, medida_d;
  logic [11:0]   bcd;
  logic          bcd_clr, bcd_en;
  logic          rise, fall;

  assign sync_d = {sync_q[1:0], echo};
  assign rise   = sync_q[1] & ~sync_q[2];
  assign fall   = ~sync_q[1] & sync_q[2];

  contador_bcd_3dig u_cm (
    .clk   (clock),
    .clr   (bcd_clr | ~reset),
    .en    (bcd_en),
    .limit (TO_BCD(MAX_CM)),
    .count (bcd)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    bcd_clr   = 1'b0;
    bcd_en    = 1'b0;
    trigger_d = 1'b0;
    pronto_d  = (state_q == S_DONE);
    medida_d  = (state_q == S_DONE) ? bcd : medida_q;
    unique case (state_q)
      S_IDLE: begin
        if (medir) begin
          state_d   = S_TRIG;
          cnt_d     = '0;
          tick_d    = '0;
          bcd_clr   = 1'b1;
          trigger_d = 1'b1;
        end
      end
      S_TRIG: begin
        if (cnt_q == CW'(TRIG_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          trigger_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (rise) begin
          state_d = S_MEAS;
          tick_d  = TW'(CYCLES_PER_CM / 2);
          cnt_d   = '0;
        end
`ifdef SONAR_TIMEOUT_EN
        else if (cnt_q == CW'(TOUT_CYC - 1)) begin
          state_d = S_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_MEAS: begin
        // half-cm preload above turns truncation into rounding
        if (tick_q == TW'(CYCLES_PER_CM - 1)) begin
          tick_d = '0;
          bcd_en = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (fall) begin
          state_d = S_DONE;
        end
`ifdef SONAR_TIMEOUT_EN
        else if (cnt_q == CW'(TOUT_CYC - 1)) begin
          state_d = S_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tick_q    <= '0;
      sync_q    <= '0;
      trigger_q <= 1'b0;
      pronto_q  <= 1'b0;
      medida_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sync_q    <= sync_d;
      trigger_q <= trigger_d;
      pronto_q  <= pronto_d;
      medida_q  <= medida_d;
    end
  end

`ifdef SONAR_TIMEOUT_EN
  logic erro_q, erro_d;
  assign erro_d = (state_q == S_TOUT);
  always_ff @(posedge clock) begin
    if (!reset) erro_q <= 1'b0;
    else        erro_q <= erro_d;
  end
  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

  assign trigger   = trigger_q;
  assign pronto    = pronto_q;
  assign medida    = medida_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_interface_sonar_param.sv
// Scoreboard bench for interface_sonar_param, scaled-down clock.
// Random echo widths checked against an arithmetic rounding model.
module tb_interface_sonar_param;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned TRIG_US = 4;
  localparam int unsigned CPC = 8;
  localparam int unsigned MAXC = 50;
  localparam int unsigned TOUT_US = 1000;
  localparam int TRIG_CYC = 4;
  localparam int TOUT_CYC = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int n_chk = 0;
  int n_pass = 0;
  int trig_len = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = 12'h000;

  interface_sonar_param #(
    .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .CYCLES_PER_CM(CPC),
    .MAX_CM(MAXC), .TIMEOUT_US(TOUT_US)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo),
    .trigger(trigger), .medida(medida), .pronto(pronto),
    .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] ref_cm(input int h);
    int cm;
    cm = (2 * h + int'(CPC)) / (2 * int'(CPC));
    if (cm > int'(MAXC)) cm = int'(MAXC);
    return {4'(cm / 100), 4'(cm / 10 % 10), 4'(cm % 10)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return trigger;
      1: return pronto;
      default: return erro;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic lvl,
                          input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (sel(which) == lvl) return;
    end
    n_chk++;
    $display("FAIL %s: timed out after %0d cycles", nm, lim);
  endtask

  // monitor: pops the scoreboard on each pronto
  always @(negedge clock) begin
    if (reset) begin
      if (pronto) begin
        if (exp_q.size() == 0) begin
          chk("pronto_unexpected", 1, 0);
        end else begin
          chk("medida", int'(medida), int'(exp_q.pop_front()));
        end
      end
      if (trigger) begin
        trig_len++;
      end else if (trig_len != 0) begin
        chk("trigger_width", trig_len, TRIG_CYC);
        trig_len = 0;
      end
    end else begin
      trig_len = 0;
    end
  end

  task automatic echo_pulse(input int h, input int d);
    repeat (d) @(negedge clock);
    echo = 1'b1;
    last_exp = ref_cm(h);
    exp_q.push_back(last_exp);
    repeat (h) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic measure(input int h, input int d);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_sig(0, 1'b1, 5, "trigger_rise");
    wait_sig(0, 1'b0, 20, "trigger_fall");
    echo_pulse(h, d);
    wait_sig(1, 1'b1, 20, "pronto_wait");
    @(negedge clock);
  endtask

  initial begin
    int dirs[10];
    int n;
    dirs = '{200, 100, 99, 3, 4, 403, 404, 460, 396, 395};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_medida", int'(medida), 0);
    chk("rst_state", int'(db_estado), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    foreach (dirs[i]) measure(dirs[i], 1 + (i % 4));
    for (int i = 0; i < 20; i++)
      measure(int'($urandom_range(1, 460)), int'($urandom_range(0, 30)));

    // echo already high on entry to WAIT_ECHO
    echo = 1'b1;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_sig(0, 1'b1, 5, "trigger_rise");
    wait_sig(0, 1'b0, 20, "trigger_fall");
    repeat (30) @(negedge clock);
    chk("echo_high_waits", int'(db_estado), 2);
    echo = 1'b0;
    repeat (10) @(negedge clock);
    chk("no_early_pronto", exp_q.size(), 0);
    echo_pulse(200, 0);
    wait_sig(1, 1'b1, 20, "pronto_wait");
    @(negedge clock);

    // back-to-back with medir held
    medir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_sig(0, 1'b1, 10, "b2b_trigger_rise");
      wait_sig(0, 1'b0, 20, "b2b_trigger_fall");
      echo_pulse(k == 0 ? 300 : (k == 1 ? 150 : 100), 5);
      wait_sig(1, 1'b1, 20, "b2b_pronto");
      if (k == 2) medir = 1'b0;
    end
    repeat (3) @(negedge clock);
    chk("b2b_idle", int'(db_estado), 0);

    // reset during MEASURE
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_sig(0, 1'b1, 5, "trigger_rise");
    wait_sig(0, 1'b0, 20, "trigger_fall");
    repeat (3) @(negedge clock);
    echo = 1'b1;
    repeat (50) @(negedge clock);
    chk("in_measure", int'(db_estado), 3);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_trigger", int'(trigger), 0);
    chk("midrst_medida", int'(medida), 0);
    chk("midrst_state", int'(db_estado), 0);
    echo = 1'b0;
    last_exp = 12'h000;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    measure(250, 2);

`ifdef SONAR_TIMEOUT_EN
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_sig(0, 1'b1, 5, "trigger_rise");
    wait_sig(0, 1'b0, 20, "trigger_fall");
    n = 0;
    for (int i = 1; i <= TOUT_CYC + 50; i++) begin
      @(negedge clock);
      if (erro) begin
        n = i;
        break;
      end
    end
    chk("timeout_delay", n, TOUT_CYC + 1);
    chk("timeout_medida", int'(medida), int'(last_exp));
    chk("timeout_state", int'(db_estado), 0);
    @(negedge clock);
    chk("erro_one_cycle", int'(erro), 0);
`else
    n = 0;
    chk("erro_tied", int'(erro), n);
`endif

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
